vga_timing: RTL
===============

// Module: vga_timing
// PURPOSE
//  Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock.
//  Drives `active` (consumed by mixer), pixel coordinates for the background/sprite layers,
//  VGA hsync/vsync, and DAC blank_n/sync_n.
//  Sits directly upstream of mixer; all layers index their pixels with x/y.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
// PORTS
//  clk          in   1   pixel clock, 25 MHz
//  reset_n      in   1   asynchronous reset, active low
//  pix_en       in   1   pixel advance enable; tie 1 for one pixel per clk
//  x            out  10  horizontal counter of current pixel, 0..H_TOTAL-1
//  y            out  10  vertical counter of current pixel, 0..V_TOTAL-1
//  active       out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  vga_hs       out  1   horizontal sync, active low
//  vga_vs       out  1   vertical sync, active low
//  vga_blank_n  out  1   equals active (DAC blanking)
//  vga_sync_n   out  1   constant 0 (no sync-on-green)
//  line_start   out  1   1-cycle pulse when x==0
//  frame_start  out  1   1-cycle pulse when x==0 and y==0
// BEHAVIOUR
//  - One clock domain (clk). Asynchronous active-low reset on reset_n.
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
//  - Counters and all outputs are registers; outputs are never decoded combinationally at the port.
//  - Reset values: x=0, y=0, active=0, vga_blank_n=0, vga_hs=1, vga_vs=1, line_start=0, frame_start=0.
//  - First clk edge with pix_en=1 after reset release presents pixel (0,0): active=1, line_start=1, frame_start=1.
//  - On each clk edge with pix_en=1, outputs advance one pixel.
//  - Horizontal wrap: x increments; at x==H_TOTAL-1 the next pixel is x=0 and y increments.
//  - Vertical wrap: at x==H_TOTAL-1 and y==V_TOTAL-1 the next pixel is (0,0).
//  - pix_en=0: every output holds, including line_start and frame_start. A pulse therefore lasts exactly one enabled pixel.
//  - vga_hs=0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x = 656..751.
//  - vga_vs=0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y = 490..491. vga_vs is evaluated on y only and spans whole lines.
//  - All output bits for a given pixel are updated on the same edge, so x, y and active stay coherent for downstream lookups.
//  - Reset asserted mid-frame: all outputs return to reset values immediately (async). Raster restarts at (0,0).
//  - Counter widths: 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.
// CONFIGURATION
//  VGA_TIMING_FRAME_CNT_EN:
//    - Defined: adds port frame_cnt (out, 8 bits).
//      Reset value 0. Increments on the same edge that frame_start rises. Wraps 255 -> 0.
//      Used for sprite animation.
//    - Undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  - Reset release with pix_en=1 -> first edge: x=0, y=0, active=1, frame_start=1, line_start=1, vga_hs=1, vga_vs=1.
//  - Run 800 enabled cycles -> active=0 for x=640..799; vga_hs=0 for exactly 96 cycles (x=656..751);
//    line_start pulses again at x=0 with y=1.
//  - Run full frame (420000 cycles) -> vga_vs low for exactly 1600 cycles (y=490..491); frame_start period = 420000 cycles.
//  - pix_en toggled 1/0 every cycle -> raster advances at half rate; line_start high for 2 clk cycles; x,y,active coherent.
//  - reset_n pulsed low at x=300, y=200 -> outputs go to reset values before the next edge; restart at (0,0).
//  - VGA_TIMING_FRAME_CNT_EN defined, 256 frames -> frame_cnt counts 0..255 then 0; increments align with frame_start.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing (master) to the mixer and pixel layers (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (
        input  pix_en,
        output x, y, active, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               line_start, frame_start, frame_cnt
    );
    modport slave (
        output pix_en,
        input  x, y, active, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               line_start, frame_start, frame_cnt
    );
`else
    modport master (
        input  pix_en,
        output x, y, active, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               line_start, frame_start
    );
    modport slave (
        output pix_en,
        input  x, y, active, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: registered x/y, active, syncs and line/frame pulses.
// Optional 8-bit frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    vga_timing_if.master vt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // ST_IDLE: out of reset, the next enabled edge presents pixel (0,0) rather than (1,0).
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_x, r_y;
    logic [9:0] w_x_nxt, w_y_nxt;
    logic       r_active, r_hs, r_vs, r_line_start, r_frame_start;
    logic       w_active_nxt, w_hs_nxt, w_vs_nxt, w_line_nxt, w_frame_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments on every flop so all registers sample pre-edge values.
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (vt.pix_en) begin
            w_state_nxt = ST_RUN;
            if (r_state == ST_IDLE) begin
                w_x_nxt = '0;
                w_y_nxt = '0;
            end else if (r_x == H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Decode the upcoming pixel so every output flop loads on the same edge as x/y.
    always_comb begin
        w_active_nxt = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
        w_hs_nxt     = !((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
        w_vs_nxt     = !((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
        w_line_nxt   = (w_x_nxt == 10'd0);
        w_frame_nxt  = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (vt.pix_en) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_active      <= w_active_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_line_start  <= w_line_nxt;
            r_frame_start <= w_frame_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      r_frame_cnt <= '0;
        else if (vt.pix_en && w_frame_nxt) r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign vt.frame_cnt = r_frame_cnt;
`endif

    assign vt.x           = r_x;
    assign vt.y           = r_y;
    assign vt.active      = r_active;
    assign vt.vga_hs      = r_hs;
    assign vt.vga_vs      = r_vs;
    assign vt.vga_blank_n = r_active;
    assign vt.vga_sync_n  = 1'b0;
    assign vt.line_start  = r_line_start;
    assign vt.frame_start = r_frame_start;
endmodule
